// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle arithmetic/logic ops and bit-serial shifts
module alu_multicycle #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             carry_i,
    input  logic [3:0]       alu_op_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             neg_o,
    output logic             ovf_o,
    output logic             illegal_o
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_val_q, sh_val_d;
    logic [CNT_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [1:0]         sh_op_q, sh_op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d, carry_q, carry_d, neg_q, neg_d;
    logic               ovf_q, ovf_d, illegal_q, illegal_d, done_q, done_d;

    logic [WIDTH:0]     add_w, sub_w;
    logic               cin_w;
    logic [WIDTH-1:0]   step_val;
    logic               step_out;
    logic               complete_c, carry_c, ovf_c;
    logic [WIDTH-1:0]   res_c;

    // Carry-in only participates for the ADC/SBC encodings (opcode bit 0 set)
    assign cin_w = alu_op_i[0] & carry_i;
    assign add_w = {1'b0, rs_i} + {1'b0, op2_i} + {{WIDTH{1'b0}}, cin_w};
    assign sub_w = {1'b0, rs_i} - {1'b0, op2_i} - {{WIDTH{1'b0}}, cin_w};

    // One-bit shift step; step_out is the bit leaving the word on this step
    always_comb begin
        step_val = sh_val_q;
        step_out = 1'b0;
        case (sh_op_q)
            2'b00: begin
                step_val = {sh_val_q[WIDTH-2:0], 1'b0};
                step_out = sh_val_q[WIDTH-1];
            end
            2'b01: begin
                step_val = {1'b0, sh_val_q[WIDTH-1:1]};
                step_out = sh_val_q[0];
            end
            2'b10: begin
                step_val = {sh_val_q[WIDTH-1], sh_val_q[WIDTH-1:1]};
                step_out = sh_val_q[0];
            end
            default: begin
                step_val = {sh_val_q[WIDTH-2:0], sh_val_q[WIDTH-1]};
                step_out = sh_val_q[WIDTH-1];
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sh_val_d   = sh_val_q;
        sh_cnt_d   = sh_cnt_q;
        sh_op_d    = sh_op_q;
        res_d      = res_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        illegal_d  = illegal_q;
        done_d     = 1'b0;
        complete_c = 1'b0;
        res_c      = '0;
        carry_c    = 1'b0;
        ovf_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    casez (alu_op_i)
                        4'b000?: begin
                            complete_c = 1'b1;
                            res_c      = add_w[WIDTH-1:0];
                            carry_c    = add_w[WIDTH];
                            ovf_c      = (rs_i[WIDTH-1] == op2_i[WIDTH-1]) &&
                                         (add_w[WIDTH-1] != rs_i[WIDTH-1]);
                        end
                        4'b001?: begin
                            complete_c = 1'b1;
                            res_c      = sub_w[WIDTH-1:0];
                            carry_c    = sub_w[WIDTH];
                            ovf_c      = (rs_i[WIDTH-1] != op2_i[WIDTH-1]) &&
                                         (sub_w[WIDTH-1] != rs_i[WIDTH-1]);
                        end
                        4'b0100: begin complete_c = 1'b1; res_c = rs_i & op2_i;  end
                        4'b0101: begin complete_c = 1'b1; res_c = rs_i | op2_i;  end
                        4'b0110: begin complete_c = 1'b1; res_c = rs_i ^ op2_i;  end
                        4'b0111: begin complete_c = 1'b1; res_c = rs_i & ~op2_i; end
                        4'b10??: begin
                            if (count_i == '0) begin
                                complete_c = 1'b1;
                                res_c      = rs_i;
                                carry_c    = carry_i;
                            end else begin
                                state_d  = S_SHIFT;
                                sh_val_d = rs_i;
                                sh_cnt_d = count_i;
                                sh_op_d  = alu_op_i[1:0];
                            end
                        end
                        default: begin
                            illegal_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                sh_val_d = step_val;
                sh_cnt_d = sh_cnt_q - CNT_W'(1);
                if (sh_cnt_q == CNT_W'(1)) begin
                    state_d    = S_IDLE;
                    complete_c = 1'b1;
                    res_c      = step_val;
                    carry_c    = step_out;
                end
            end
        endcase

        if (complete_c) begin
            res_d     = res_c;
            zero_d    = (res_c == '0);
            neg_d     = res_c[WIDTH-1];
            carry_d   = carry_c;
            ovf_d     = ovf_c;
            illegal_d = 1'b0;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sh_val_q  <= '0;
            sh_cnt_q  <= '0;
            sh_op_q   <= '0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_val_q  <= sh_val_d;
            sh_cnt_q  <= sh_cnt_d;
            sh_op_q   <= sh_op_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = (state_q == S_SHIFT);
    assign done_o    = done_q;
    assign res_o     = res_q;
    assign zero_o    = zero_q;
    assign carry_o   = carry_q;
    assign neg_o     = neg_q;
    assign ovf_o     = ovf_q;
    assign illegal_o = illegal_q;

endmodule
